// File: rtl/fpmul_operand_stage.sv
// Operand FIFO and one-at-a-time issue sequencer in front of the FP multiplier.
// Push-to-start is 2 edges when idle; in_ready drops only when the FIFO is full.

module fpmul_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 68,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign pop_dat = mem[rd_ptr];
endmodule

module fpmul_operand_stage #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic [31:0]   mul_a,
  output logic [31:0]   mul_b,
  output logic          mul_start,
  input  logic          mul_done,
  output logic [3:0]    pair_cls,
  output logic          pair_sign,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cls;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t state, state_nxt;
  entry_t in_entry, head;
  logic   push, pop;

  // Pair class bits are {NAN, INF, ZERO, DNF}; inf*zero is an invalid operation.
  function automatic logic [3:0] classify(input logic [31:0] a, input logic [31:0] b);
    logic a_emax, a_emin, a_fnz, b_emax, b_emin, b_fnz;
    logic a_nan, a_inf, a_zero, a_dnf, b_nan, b_inf, b_zero, b_dnf;
    a_emax = &a[30:23];
    a_emin = ~|a[30:23];
    a_fnz  = |a[22:0];
    b_emax = &b[30:23];
    b_emin = ~|b[30:23];
    b_fnz  = |b[22:0];
    a_nan  = a_emax & a_fnz;
    a_inf  = a_emax & ~a_fnz;
    a_zero = a_emin & ~a_fnz;
    a_dnf  = a_emin & a_fnz;
    b_nan  = b_emax & b_fnz;
    b_inf  = b_emax & ~b_fnz;
    b_zero = b_emin & ~b_fnz;
    b_dnf  = b_emin & b_fnz;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) classify = 4'b1000;
    else if (a_inf | b_inf)                                   classify = 4'b0100;
    else if (a_zero | b_zero)                                 classify = 4'b0010;
    else if (a_dnf | b_dnf)                                   classify = 4'b0001;
    else                                                      classify = 4'b0000;
  endfunction

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign in_ready = (fifo_count < FULL_CNT);
  assign push     = in_valid & in_ready;
  assign pop      = (state == S_IDLE) && (fifo_count != '0);

  always_comb begin
    in_entry     = '0;
    in_entry.a   = in_a;
    in_entry.b   = in_b;
    in_entry.cls = classify(in_a, in_b);
  end

  fpmul_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t)),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (in_entry),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (mul_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand registers load only on a pop, so they hold through the whole handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      pair_cls  <= '0;
      pair_sign <= 1'b0;
    end else if (pop) begin
      mul_a     <= head.a;
      mul_b     <= head.b;
      pair_cls  <= head.cls;
      pair_sign <= head.a[31] ^ head.b[31];
    end
  end

  assign mul_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
endmodule
